// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter:
// register offsets, STATUS/CTRL bit positions and FSM state encoding.
package mmio_uart_tx_pkg;

    // Register select, taken from address bits [3:2]
    localparam logic [1:0] RegTxdata = 2'd0;
    localparam logic [1:0] RegStatus = 2'd1;
    localparam logic [1:0] RegCtrl   = 2'd2;

    localparam int unsigned StatusBusy   = 0;
    localparam int unsigned StatusFull   = 1;
    localparam int unsigned StatusEmpty  = 2;
    localparam int unsigned StatusOvf    = 3;
    localparam int unsigned StatusCntLsb = 8;
    localparam int unsigned StatusCntW   = 4;

    localparam int unsigned CtrlTxEn  = 0;
    localparam int unsigned CtrlIrqEn = 1;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with registered occupancy count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_tx_fifo #(
    parameter int unsigned Depth = 8,
    parameter int unsigned Width = 8,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic            pop_i,
    output logic [Width-1:0] rdata_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [CntW-1:0] count_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register file, TX FIFO, frame FSM and baud counter.
// o_tx is registered from the FSM, so the line lags the FSM state by one cycle.
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned CLK_DIV    = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_sel,
    input  logic             i_we,
    input  logic [3:0]       i_add,
    input  logic [WIDTH-1:0] i_w_data,
    output logic [WIDTH-1:0] o_r_data,
    output logic             o_tx,
    output logic             o_irq
);

    localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned BaudW = $clog2(CLK_DIV);
    localparam logic [BaudW-1:0] BaudLoad = BaudW'(CLK_DIV - 1);

    tx_state_e        state_q;
    logic [BaudW-1:0] baud_q;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       shreg_q;
    logic             tx_q;
    logic             tx_en_q;
    logic             irq_en_q;
    logic             ovf_q;

    logic             wr_en;
    logic [1:0]       reg_sel;
    logic             push;
    logic             bit_end;
    logic             start_frame;
    logic             push_rejected;
    logic [7:0]       fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CntW-1:0]  fifo_count;
    logic             unused_bits;

    assign wr_en   = i_sel && i_we && !i_rst;
    assign reg_sel = i_add[3:2];
    assign push    = wr_en && (reg_sel == RegTxdata);
    assign bit_end = (baud_q == '0);

    // A new frame starts from IDLE, or straight out of the last STOP cycle with no gap
    assign start_frame = tx_en_q && !fifo_empty &&
                         ((state_q == StIdle) || ((state_q == StStop) && bit_end));
    assign push_rejected = push && fifo_full && !start_frame;

    uart_tx_fifo #(
        .Depth (FIFO_DEPTH),
        .Width (8)
    ) u_fifo (
        .clk_i   (i_clk),
        .rst_i   (i_rst),
        .push_i  (push),
        .wdata_i (i_w_data[7:0]),
        .pop_i   (start_frame),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ovf_q    <= 1'b0;
            tx_en_q  <= 1'b1;
            irq_en_q <= 1'b0;
        end else begin
            if (push_rejected) begin
                ovf_q <= 1'b1;
            end else if (wr_en && (reg_sel == RegStatus) && i_w_data[StatusOvf]) begin
                ovf_q <= 1'b0;
            end
            if (wr_en && (reg_sel == RegCtrl)) begin
                tx_en_q  <= i_w_data[CtrlTxEn];
                irq_en_q <= i_w_data[CtrlIrqEn];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= StIdle;
            baud_q    <= BaudLoad;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            baud_q <= bit_end ? BaudLoad : baud_q - 1'b1;
            unique case (state_q)
                StIdle: begin
                    tx_q   <= 1'b1;
                    baud_q <= BaudLoad;
                    if (start_frame) begin
                        state_q <= StStart;
                        shreg_q <= fifo_rdata;
                    end
                end
                StStart: begin
                    tx_q <= 1'b0;
                    if (bit_end) begin
                        state_q   <= StData;
                        bit_cnt_q <= '0;
                    end
                end
                StData: begin
                    tx_q <= shreg_q[0];
                    if (bit_end) begin
                        shreg_q   <= {1'b0, shreg_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) state_q <= StStop;
                    end
                end
                StStop: begin
                    tx_q <= 1'b1;
                    if (bit_end) begin
                        if (start_frame) begin
                            state_q <= StStart;
                            shreg_q <= fifo_rdata;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        o_r_data = '0;
        case (reg_sel)
            RegStatus: begin
                o_r_data[StatusBusy]  = (state_q != StIdle);
                o_r_data[StatusFull]  = fifo_full;
                o_r_data[StatusEmpty] = fifo_empty;
                o_r_data[StatusOvf]   = ovf_q;
                o_r_data[StatusCntLsb +: StatusCntW] = StatusCntW'(fifo_count);
            end
            RegCtrl: begin
                o_r_data[CtrlTxEn]  = tx_en_q;
                o_r_data[CtrlIrqEn] = irq_en_q;
            end
            default: ;
        endcase
    end

    assign o_tx  = tx_q;
    assign o_irq = irq_en_q && fifo_empty && (state_q == StIdle);

    assign unused_bits = ^{i_add[1:0], i_w_data[WIDTH-1:8]};

endmodule
